// File: rtl/bias_update_seq.sv
// Bias-update sequencer: for one layer, reads each bias, strobes the bias calculator,
// then writes the calculator's registered result back to the same BRAM address.
module bias_update_seq #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 10,
    parameter int unsigned HiddenNeuron = 16,
    parameter int unsigned OutNeuron    = 4,
    parameter int unsigned Layer        = 3,
    parameter int unsigned BIAS_BASE    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        layer_sel,
    input  logic [DWIDTH-1:0] new_bias,
    output logic              bram_en,
    output logic              bram_we,
    output logic [AWIDTH-1:0] bram_addr,
    output logic [DWIDTH-1:0] bram_din,
    output logic [4:0]        delta_addr,
    output logic              en_b_back,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned LastLayer = Layer - 2;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCalc,
        StWrite,
        StDone
    } state_e;

    state_e     state;
    logic [1:0] layer_q;
    logic [4:0] idx_q;

    function automatic logic [AWIDTH-1:0] base_of(input logic [1:0] l);
        return AWIDTH'(BIAS_BASE) + AWIDTH'(l) * AWIDTH'(HiddenNeuron);
    endfunction

    function automatic logic [4:0] last_idx(input logic [1:0] l);
        return (32'(l) == LastLayer) ? 5'(OutNeuron - 1) : 5'(HiddenNeuron - 1);
    endfunction

    assign bram_din = new_bias;

    // Outputs are loaded with the values of the state being entered, so they
    // behave as a Moore decode of the registered state without any glitching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            layer_q    <= 2'd0;
            idx_q      <= 5'd0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            delta_addr <= 5'd0;
            en_b_back  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            en_b_back <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (32'(layer_sel) <= LastLayer) begin
                            layer_q    <= layer_sel;
                            idx_q      <= 5'd0;
                            state      <= StRead;
                            busy       <= 1'b1;
                            bram_en    <= 1'b1;
                            bram_we    <= 1'b0;
                            bram_addr  <= base_of(layer_sel);
                            delta_addr <= 5'd0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    state     <= StCalc;
                    bram_en   <= 1'b0;
                    en_b_back <= 1'b1;
                end
                StCalc: begin
                    // bram_addr still holds base+idx from the read
                    state   <= StWrite;
                    bram_en <= 1'b1;
                    bram_we <= 1'b1;
                end
                StWrite: begin
                    bram_we <= 1'b0;
                    if (idx_q == last_idx(layer_q)) begin
                        state      <= StDone;
                        bram_en    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        bram_addr  <= '0;
                        delta_addr <= 5'd0;
                    end else begin
                        idx_q      <= idx_q + 5'd1;
                        state      <= StRead;
                        bram_en    <= 1'b1;
                        bram_addr  <= base_of(layer_q) + AWIDTH'(idx_q + 5'd1);
                        delta_addr <= idx_q + 5'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    idx_q <= 5'd0;
                end
                default: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
